// File: rtl/ahb_pkg.sv
// Shared encodings for the two-master AHB-Lite arbiter: transfer and response
// codes, grant FSM states and the data-phase owner encoding.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Address-phase grant: IDLE parks the bus with HTRANS=IDLE.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    // Which requester currently owns the bus data phase.
    typedef enum logic [1:0] {
        DOWN_NONE = 2'd0,
        DOWN_P0   = 2'd1,
        DOWN_P1   = 2'd2
    } downer_t;

endpackage

// File: rtl/ahb_arb_input_stage.sv
// One-entry address-phase buffer for a single requester. Holds a transfer the
// requester believes was accepted but which the shared bus has not yet taken,
// and presents either the buffered or the live fields to the arbiter.
module ahb_arb_input_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cap,
    input  logic                  i_clr,
    input  logic [ADDR_WIDTH-1:0] i_haddr,
    input  logic                  i_hwrite,
    input  logic [1:0]            i_htrans,
    input  logic [2:0]            i_hsize,
    input  logic [2:0]            i_hburst,
    input  logic [3:0]            i_hprot,
    input  logic                  i_hmastlock,
    output logic                  o_pend,
    output logic [ADDR_WIDTH-1:0] o_haddr,
    output logic                  o_hwrite,
    output logic [1:0]            o_htrans,
    output logic [2:0]            o_hsize,
    output logic [2:0]            o_hburst,
    output logic [3:0]            o_hprot,
    output logic                  o_hmastlock
);

    logic                  r_pend;
    logic [ADDR_WIDTH-1:0] r_haddr;
    logic                  r_hwrite;
    logic [1:0]            r_htrans;
    logic [2:0]            r_hsize;
    logic [2:0]            r_hburst;
    logic [3:0]            r_hprot;
    logic                  r_hmastlock;

    // Pending flag: set on capture, cleared once the buffered transfer is taken.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= 1'b0;
        end else if (i_cap) begin
            r_pend <= 1'b1;
        end else if (i_clr) begin
            r_pend <= 1'b0;
        end
    end

    // Field storage is only meaningful while r_pend is set, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (i_cap) begin
            r_haddr     <= i_haddr;
            r_hwrite    <= i_hwrite;
            r_htrans    <= i_htrans;
            r_hsize     <= i_hsize;
            r_hburst    <= i_hburst;
            r_hprot     <= i_hprot;
            r_hmastlock <= i_hmastlock;
        end
    end

    // Buffered fields take precedence over live ones while a transfer is pending.
    always_comb begin
        o_pend      = r_pend;
        o_haddr     = r_pend ? r_haddr     : i_haddr;
        o_hwrite    = r_pend ? r_hwrite    : i_hwrite;
        o_htrans    = r_pend ? r_htrans    : i_htrans;
        o_hsize     = r_pend ? r_hsize     : i_hsize;
        o_hburst    = r_pend ? r_hburst    : i_hburst;
        o_hprot     = r_pend ? r_hprot     : i_hprot;
        o_hmastlock = r_pend ? r_hmastlock : i_hmastlock;
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: p0 = load/store, p1 = code fetch, shared onto a
// single master port. Optional build macro AHB_ARB_RR_EN selects round-robin
// on contention; without it p0 has fixed priority.
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [ADDR_WIDTH-1:0] p0_haddr,
    input  logic [DATA_WIDTH-1:0] p0_hwdata,
    input  logic                  p0_hwrite,
    input  logic [1:0]            p0_htrans,
    input  logic [2:0]            p0_hsize,
    input  logic [2:0]            p0_hburst,
    input  logic [3:0]            p0_hprot,
    input  logic                  p0_hmastlock,
    output logic [DATA_WIDTH-1:0] p0_hrdata,
    output logic                  p0_hready,
    output logic                  p0_hresp,
    input  logic [ADDR_WIDTH-1:0] p1_haddr,
    input  logic [DATA_WIDTH-1:0] p1_hwdata,
    input  logic                  p1_hwrite,
    input  logic [1:0]            p1_htrans,
    input  logic [2:0]            p1_hsize,
    input  logic [2:0]            p1_hburst,
    input  logic [3:0]            p1_hprot,
    input  logic                  p1_hmastlock,
    output logic [DATA_WIDTH-1:0] p1_hrdata,
    output logic                  p1_hready,
    output logic                  p1_hresp,
    output logic [ADDR_WIDTH-1:0] m_haddr,
    output logic [DATA_WIDTH-1:0] m_hwdata,
    output logic                  m_hwrite,
    output logic [1:0]            m_htrans,
    output logic [2:0]            m_hsize,
    output logic [2:0]            m_hburst,
    output logic [3:0]            m_hprot,
    output logic                  m_hmastlock,
    input  logic [DATA_WIDTH-1:0] m_hrdata_in,
    input  logic                  m_hready_in,
    input  logic                  m_hresp_in
);

    arb_state_t            r_state;
    arb_state_t            w_sel;
    downer_t               r_downer;
    logic                  w_hold;
    logic                  w_win1;
    logic [1:0]            w_req;
    logic [1:0]            w_cap;
    logic [1:0]            w_clr;
    logic [1:0]            w_own;
    logic [1:0]            w_pend;
    logic [ADDR_WIDTH-1:0] w_eaddr  [2];
    logic                  w_ewrite [2];
    logic [1:0]            w_etrans [2];
    logic [2:0]            w_esize  [2];
    logic [2:0]            w_eburst [2];
    logic [3:0]            w_eprot  [2];
    logic                  w_elock  [2];

    ahb_arb_input_stage #(.ADDR_WIDTH(ADDR_WIDTH)) u_stage0 (
        .i_clk(HCLK), .i_rst_n(HRESETn), .i_cap(w_cap[0]), .i_clr(w_clr[0]),
        .i_haddr(p0_haddr), .i_hwrite(p0_hwrite), .i_htrans(p0_htrans),
        .i_hsize(p0_hsize), .i_hburst(p0_hburst), .i_hprot(p0_hprot),
        .i_hmastlock(p0_hmastlock), .o_pend(w_pend[0]),
        .o_haddr(w_eaddr[0]), .o_hwrite(w_ewrite[0]), .o_htrans(w_etrans[0]),
        .o_hsize(w_esize[0]), .o_hburst(w_eburst[0]), .o_hprot(w_eprot[0]),
        .o_hmastlock(w_elock[0])
    );

    ahb_arb_input_stage #(.ADDR_WIDTH(ADDR_WIDTH)) u_stage1 (
        .i_clk(HCLK), .i_rst_n(HRESETn), .i_cap(w_cap[1]), .i_clr(w_clr[1]),
        .i_haddr(p1_haddr), .i_hwrite(p1_hwrite), .i_htrans(p1_htrans),
        .i_hsize(p1_hsize), .i_hburst(p1_hburst), .i_hprot(p1_hprot),
        .i_hmastlock(p1_hmastlock), .o_pend(w_pend[1]),
        .o_haddr(w_eaddr[1]), .o_hwrite(w_ewrite[1]), .o_htrans(w_etrans[1]),
        .o_hsize(w_esize[1]), .o_hburst(w_eburst[1]), .o_hprot(w_eprot[1]),
        .o_hmastlock(w_elock[1])
    );

    assign w_req[0] = w_etrans[0][1];
    assign w_req[1] = w_etrans[1][1];

`ifdef AHB_ARB_RR_EN
    logic r_last;  // 1 = p1 was granted last

    // Round-robin pointer follows every transfer actually issued on the bus.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_last <= 1'b1;
        end else if (m_hready_in && m_htrans[1]) begin
            r_last <= (w_sel == ARB_GNT1);
        end
    end

    assign w_win1 = w_req[1] & (~w_req[0] | ~r_last);
`else
    assign w_win1 = w_req[1] & ~w_req[0];
`endif

    // Grant state register: records who owns the current address phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_sel;
        end
    end

    // Next grant: re-arbitrate only at an accepted address phase, and never
    // while the owner is mid-burst (SEQ/BUSY) or holding a locked sequence.
    // The chosen port drives the bus this same cycle.
    always_comb begin
        w_hold = 1'b0;
        w_sel  = r_state;
        case (r_state)
            ARB_GNT0: w_hold = (w_etrans[0] == HTRANS_SEQ) || (w_etrans[0] == HTRANS_BUSY) || w_elock[0];
            ARB_GNT1: w_hold = (w_etrans[1] == HTRANS_SEQ) || (w_etrans[1] == HTRANS_BUSY) || w_elock[1];
            default:  w_hold = 1'b0;
        endcase
        if (m_hready_in && !w_hold) begin
            if (w_req[0] || w_req[1]) begin
                w_sel = w_win1 ? ARB_GNT1 : ARB_GNT0;
            end else begin
                w_sel = ARB_IDLE;
            end
        end
    end

    // A live transfer is taken directly only if its port is granted, nothing is
    // buffered ahead of it and the bus accepts it now; otherwise it is captured.
    always_comb begin
        w_own[0] = (w_sel == ARB_GNT0) && !w_pend[0] && m_hready_in;
        w_own[1] = (w_sel == ARB_GNT1) && !w_pend[1] && m_hready_in;
        w_cap[0] = p0_hready && p0_htrans[1] && !w_own[0];
        w_cap[1] = p1_hready && p1_htrans[1] && !w_own[1];
        w_clr[0] = w_pend[0] && (w_sel == ARB_GNT0) && m_hready_in;
        w_clr[1] = w_pend[1] && (w_sel == ARB_GNT1) && m_hready_in;
    end

    // Address-phase mux; an ungranted bus shows IDLE with all fields zero.
    always_comb begin
        m_haddr     = '0;
        m_hwrite    = 1'b0;
        m_htrans    = HTRANS_IDLE;
        m_hsize     = '0;
        m_hburst    = '0;
        m_hprot     = '0;
        m_hmastlock = 1'b0;
        if (w_sel == ARB_GNT0) begin
            m_haddr     = w_eaddr[0];
            m_hwrite    = w_ewrite[0];
            m_htrans    = w_etrans[0];
            m_hsize     = w_esize[0];
            m_hburst    = w_eburst[0];
            m_hprot     = w_eprot[0];
            m_hmastlock = w_elock[0];
        end else if (w_sel == ARB_GNT1) begin
            m_haddr     = w_eaddr[1];
            m_hwrite    = w_ewrite[1];
            m_htrans    = w_etrans[1];
            m_hsize     = w_esize[1];
            m_hburst    = w_eburst[1];
            m_hprot     = w_eprot[1];
            m_hmastlock = w_elock[1];
        end
    end

    // Data-phase owner advances with each accepted address phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_downer <= DOWN_NONE;
        end else if (m_hready_in) begin
            if (!m_htrans[1]) begin
                r_downer <= DOWN_NONE;
            end else begin
                r_downer <= (w_sel == ARB_GNT1) ? DOWN_P1 : DOWN_P0;
            end
        end
    end

    // Data-phase steering: write data from the owner, ready/response back to it.
    always_comb begin
        m_hwdata  = (r_downer == DOWN_P0) ? p0_hwdata :
                    (r_downer == DOWN_P1) ? p1_hwdata : '0;
        p0_hrdata = m_hrdata_in;
        p1_hrdata = m_hrdata_in;
        p0_hready = ((r_downer == DOWN_P0) ? m_hready_in : 1'b1) & ~w_pend[0];
        p1_hready = ((r_downer == DOWN_P1) ? m_hready_in : 1'b1) & ~w_pend[1];
        p0_hresp  = (r_downer == DOWN_P0) ? m_hresp_in : HRESP_OKAY;
        p1_hresp  = (r_downer == DOWN_P1) ? m_hresp_in : HRESP_OKAY;
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter in its default (fixed-priority) build.
module tb_ahb_master_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] p0_haddr, p0_hwdata, p0_hrdata;
    logic        p0_hwrite, p0_hmastlock, p0_hready, p0_hresp;
    logic [1:0]  p0_htrans;
    logic [2:0]  p0_hsize, p0_hburst;
    logic [3:0]  p0_hprot;
    logic [31:0] p1_haddr, p1_hwdata, p1_hrdata;
    logic        p1_hwrite, p1_hmastlock, p1_hready, p1_hresp;
    logic [1:0]  p1_htrans;
    logic [2:0]  p1_hsize, p1_hburst;
    logic [3:0]  p1_hprot;
    logic [31:0] m_haddr, m_hwdata, m_hrdata_in;
    logic        m_hwrite, m_hmastlock, m_hready_in, m_hresp_in;
    logic [1:0]  m_htrans;
    logic [2:0]  m_hsize, m_hburst;
    logic [3:0]  m_hprot;

    int checks   = 0;
    int failures = 0;

    ahb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .p0_haddr(p0_haddr), .p0_hwdata(p0_hwdata), .p0_hwrite(p0_hwrite),
        .p0_htrans(p0_htrans), .p0_hsize(p0_hsize), .p0_hburst(p0_hburst),
        .p0_hprot(p0_hprot), .p0_hmastlock(p0_hmastlock), .p0_hrdata(p0_hrdata),
        .p0_hready(p0_hready), .p0_hresp(p0_hresp),
        .p1_haddr(p1_haddr), .p1_hwdata(p1_hwdata), .p1_hwrite(p1_hwrite),
        .p1_htrans(p1_htrans), .p1_hsize(p1_hsize), .p1_hburst(p1_hburst),
        .p1_hprot(p1_hprot), .p1_hmastlock(p1_hmastlock), .p1_hrdata(p1_hrdata),
        .p1_hready(p1_hready), .p1_hresp(p1_hresp),
        .m_haddr(m_haddr), .m_hwdata(m_hwdata), .m_hwrite(m_hwrite),
        .m_htrans(m_htrans), .m_hsize(m_hsize), .m_hburst(m_hburst),
        .m_hprot(m_hprot), .m_hmastlock(m_hmastlock),
        .m_hrdata_in(m_hrdata_in), .m_hready_in(m_hready_in), .m_hresp_in(m_hresp_in)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_p0(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic lk);
        p0_htrans = tr; p0_haddr = a; p0_hwrite = w; p0_hmastlock = lk;
    endtask

    task automatic set_p1(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic lk);
        p1_htrans = tr; p1_haddr = a; p1_hwrite = w; p1_hmastlock = lk;
    endtask

    task automatic all_idle();
        set_p0(2'b00, 32'h0, 1'b0, 1'b0);
        set_p1(2'b00, 32'h0, 1'b0, 1'b0);
        p0_hwdata = 32'h0; p1_hwdata = 32'h0;
        p0_hsize = 3'd2; p1_hsize = 3'd2;
        p0_hburst = 3'd0; p1_hburst = 3'd0;
        p0_hprot = 4'h3; p1_hprot = 4'h3;
        m_hready_in = 1'b1; m_hresp_in = 1'b0;
    endtask

    initial begin
        all_idle();
        m_hrdata_in = 32'hDEAD_BEEF;
        HRESETn = 1'b0;
        #12;
        // Reset state
        check("rst_htrans",  m_htrans, 2'b00);
        check("rst_haddr",   m_haddr, 32'h0);
        check("rst_hwdata",  m_hwdata, 32'h0);
        check("rst_p0_rdy",  p0_hready, 1'b1);
        check("rst_p1_rdy",  p1_hready, 1'b1);
        check("rst_p1_resp", p1_hresp, 1'b0);
        check("rst_p0_rdat", p0_hrdata, 32'hDEAD_BEEF);
        HRESETn = 1'b1;
        step();

        // Single p0 read passes straight through
        set_p0(2'b10, 32'h8000_0010, 1'b0, 1'b0);
        #1;
        check("t1_haddr",  m_haddr, 32'h8000_0010);
        check("t1_htrans", m_htrans, 2'b10);
        check("t1_p0_rdy", p0_hready, 1'b1);
        step();
        set_p0(2'b00, 32'h0, 1'b0, 1'b0);
        m_hrdata_in = 32'h1234_5678;
        #1;
        check("t1_rdata",  p0_hrdata, 32'h1234_5678);
        check("t1_p0_rdy2", p0_hready, 1'b1);
        check("t1_p1_rdy2", p1_hready, 1'b1);
        check("t1_idle",   m_htrans, 2'b00);
        step();

        // Contention: p0 wins, p1 is buffered and issued next cycle
        set_p0(2'b10, 32'h8000_0020, 1'b0, 1'b0);
        set_p1(2'b10, 32'h0000_0004, 1'b0, 1'b0);
        #1;
        check("t2_haddr0", m_haddr, 32'h8000_0020);
        check("t2_p1_rdy0", p1_hready, 1'b1);
        step();
        set_p0(2'b00, 32'h0, 1'b0, 1'b0);
        set_p1(2'b00, 32'hFFFF_FFF0, 1'b1, 1'b0);
        #1;
        check("t2_haddr1",  m_haddr, 32'h0000_0004);
        check("t2_htrans1", m_htrans, 2'b10);
        check("t2_hwrite1", m_hwrite, 1'b0);
        check("t2_p1_rdy1", p1_hready, 1'b0);
        step();
        set_p1(2'b00, 32'h0, 1'b0, 1'b0);
        #1;
        check("t2_p1_rdy2", p1_hready, 1'b1);
        check("t2_idle",    m_htrans, 2'b00);
        step();

        // p1 locked sequence holds off p0
        set_p1(2'b10, 32'h0000_0100, 1'b0, 1'b1);
        #1;
        check("t3_haddr0", m_haddr, 32'h0000_0100);
        check("t3_lock0",  m_hmastlock, 1'b1);
        step();
        set_p1(2'b10, 32'h0000_0104, 1'b0, 1'b1);
        set_p0(2'b10, 32'h8000_0030, 1'b1, 1'b0);
        #1;
        check("t3_haddr1",  m_haddr, 32'h0000_0104);
        check("t3_p0_rdy1", p0_hready, 1'b1);
        step();
        set_p1(2'b10, 32'h0000_0108, 1'b0, 1'b1);
        set_p0(2'b00, 32'h0, 1'b0, 1'b0);
        p0_hwdata = 32'hCAFE_0001;
        #1;
        check("t3_haddr2",  m_haddr, 32'h0000_0108);
        check("t3_p0_rdy2", p0_hready, 1'b0);
        step();
        set_p1(2'b00, 32'h0, 1'b0, 1'b0);
        #1;
        check("t3_haddr3",  m_haddr, 32'h8000_0030);
        check("t3_hwrite3", m_hwrite, 1'b1);
        check("t3_htrans3", m_htrans, 2'b10);
        check("t3_lock3",   m_hmastlock, 1'b0);
        step();
        #1;
        check("t3_hwdata",  m_hwdata, 32'hCAFE_0001);
        check("t3_p0_rdy4", p0_hready, 1'b1);
        check("t3_idle",    m_htrans, 2'b00);
        step();

        // Two-cycle ERROR to p0 while p1 is buffered
        set_p0(2'b10, 32'h8000_0040, 1'b1, 1'b0);
        set_p1(2'b10, 32'h0000_0008, 1'b0, 1'b0);
        #1;
        check("t4_haddr0", m_haddr, 32'h8000_0040);
        step();
        set_p0(2'b00, 32'h0, 1'b0, 1'b0);
        set_p1(2'b00, 32'h0, 1'b0, 1'b0);
        p0_hwdata = 32'h0BAD_0BAD;
        m_hready_in = 1'b0; m_hresp_in = 1'b1;
        #1;
        check("t4_p0_resp1", p0_hresp, 1'b1);
        check("t4_p0_rdy1",  p0_hready, 1'b0);
        check("t4_p1_resp1", p1_hresp, 1'b0);
        check("t4_p1_rdy1",  p1_hready, 1'b0);
        check("t4_htrans1",  m_htrans, 2'b00);
        check("t4_hwdata1",  m_hwdata, 32'h0BAD_0BAD);
        step();
        m_hready_in = 1'b1; m_hresp_in = 1'b1;
        #1;
        check("t4_p0_resp2", p0_hresp, 1'b1);
        check("t4_p0_rdy2",  p0_hready, 1'b1);
        check("t4_p1_resp2", p1_hresp, 1'b0);
        check("t4_haddr2",   m_haddr, 32'h0000_0008);
        check("t4_htrans2",  m_htrans, 2'b10);
        step();
        m_hresp_in = 1'b0;
        #1;
        check("t4_p1_rdy3",  p1_hready, 1'b1);
        check("t4_p1_resp3", p1_hresp, 1'b0);
        check("t4_p0_resp3", p0_hresp, 1'b0);
        step();

        // Reset during p1 buffered wait drops the buffered transfer
        set_p0(2'b10, 32'h8000_0050, 1'b0, 1'b0);
        set_p1(2'b10, 32'h0000_000C, 1'b0, 1'b0);
        step();
        set_p0(2'b10, 32'h8000_0054, 1'b0, 1'b0);
        set_p1(2'b00, 32'h0, 1'b0, 1'b0);
        #1;
        check("t5_p1_rdy_wait", p1_hready, 1'b0);
        check("t5_haddr_p0",    m_haddr, 32'h8000_0054);
        all_idle();
        HRESETn = 1'b0;
        #1;
        check("t5_rst_p1_rdy",  p1_hready, 1'b1);
        check("t5_rst_htrans",  m_htrans, 2'b00);
        check("t5_rst_haddr",   m_haddr, 32'h0);
        check("t5_rst_p0_rdy",  p0_hready, 1'b1);
        #4;
        HRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            check("t5_post_htrans", m_htrans, 2'b00);
            check("t5_post_p1_rdy", p1_hready, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
